// File: rtl/phase_capture_deadlock_scheduler.sv
// phase_capture_deadlock_scheduler
//   Debounces the block outputs of N_MON deadlock monitors against a
//   programmable persistence threshold and latches confirmed deadlocks into
//   sticky status. Confirmed events drain one at a time, in round-robin order,
//   onto a valid/ready report channel.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   enable              : detection active (0 = counters held at 0)
//   clear               : pulse; clears sticky, pending flags and counters
//   persist_thresh      : consecutive block cycles needed to confirm (0 acts as 1)
//   mon_block, mon_info : per-monitor block flag and axis_block_info slice
//   rpt_valid/ready     : report handshake
//   rpt_idx, rpt_info,
//   rpt_time            : report payload (monitor index, captured info, timestamp)
//   sticky, any_deadlock: confirmed-since-clear status and its OR
//
// Optional feature: define PHASE_CAPTURE_DLSCHED_TIMESTAMP_EN to build the
// free-running timestamp and per-slot capture. Without it rpt_time is 0.

// Per-monitor debounce, sticky status and pending flag.
module phase_capture_dlsched_lane #(
    parameter int INFO_W = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [15:0]       thr,
    input  logic              block,
    input  logic [INFO_W-1:0] info_in,
    input  logic              ack,
    output logic              conf,
    output logic              sticky,
    output logic              pending,
    output logic [INFO_W-1:0] info
);
    logic [15:0] cnt;

    assign conf = enable && block && (cnt == thr - 16'd1) && !sticky;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            sticky  <= 1'b0;
            pending <= 1'b0;
            info    <= '0;
        end else begin
            if (clear || !(enable && block))
                cnt <= '0;
            else if (cnt >= thr)
                cnt <= thr;  // saturate; also covers thr lowered on the fly
            else
                cnt <= cnt + 16'd1;

            // Clear beats a same-cycle confirmation.
            if (clear) begin
                sticky  <= 1'b0;
                pending <= 1'b0;
            end else if (conf) begin
                sticky  <= 1'b1;
                pending <= 1'b1;
                info    <= info_in;
            end else if (ack) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

module phase_capture_deadlock_scheduler #(
    parameter int N_MON  = 4,
    parameter int INFO_W = 1,
    parameter int TS_W   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [15:0]             persist_thresh,
    input  logic [N_MON-1:0]        mon_block,
    input  logic [N_MON*INFO_W-1:0] mon_info,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [3:0]              rpt_idx,
    output logic [INFO_W-1:0]       rpt_info,
    output logic [TS_W-1:0]         rpt_time,
    output logic [N_MON-1:0]        sticky,
    output logic                    any_deadlock
);
    typedef enum logic [0:0] {IDLE, REPORT} state_t;

    state_t                         state_q, state_d;
    logic                           load;
    logic [15:0]                    thr;
    logic [N_MON-1:0]               conf, pending, ack;
    logic [N_MON-1:0][INFO_W-1:0]   slot_info;
    logic [3:0]                     last;
    logic [3:0]                     grant_idx;
    logic [INFO_W-1:0]              grant_info;
    logic                           grant_vld;

    assign thr          = (persist_thresh == 16'd0) ? 16'd1 : persist_thresh;
    assign any_deadlock = |sticky;
    assign rpt_valid    = (state_q == REPORT);

    for (genvar g = 0; g < N_MON; g++) begin : g_lane
        assign ack[g] = (state_q == REPORT) && rpt_ready && (rpt_idx == 4'(g));

        phase_capture_dlsched_lane #(.INFO_W(INFO_W)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .clear   (clear),
            .thr     (thr),
            .block   (mon_block[g]),
            .info_in (mon_info[g*INFO_W +: INFO_W]),
            .ack     (ack[g]),
            .conf    (conf[g]),
            .sticky  (sticky[g]),
            .pending (pending[g]),
            .info    (slot_info[g])
        );
    end

    // Round-robin: pick the pending slot at the smallest distance past 'last'.
    always_comb begin
        int best_d;
        int d;
        best_d     = N_MON;
        d          = 0;
        grant_idx  = '0;
        grant_info = '0;
        grant_vld  = 1'b0;
        for (int m = 0; m < N_MON; m++) begin
            d = (m + N_MON - 1 - int'(last)) % N_MON;
            if (pending[m] && d < best_d) begin
                best_d     = d;
                grant_vld  = 1'b1;
                grant_idx  = 4'(m);
                grant_info = slot_info[m];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Pending flags are being wiped by clear; do not grant from them.
                if (grant_vld && !clear) begin
                    state_d = REPORT;
                    load    = 1'b1;
                end
            end
            REPORT: begin
                if (rpt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_idx  <= '0;
            rpt_info <= '0;
            last     <= 4'(N_MON - 1);
        end else if (load) begin
            rpt_idx  <= grant_idx;
            rpt_info <= grant_info;
            last     <= grant_idx;
        end
    end

`ifdef PHASE_CAPTURE_DLSCHED_TIMESTAMP_EN
    logic [TS_W-1:0]             ts;
    logic [N_MON-1:0][TS_W-1:0]  tstamp;
    logic [TS_W-1:0]             grant_time;

    always_comb begin
        grant_time = '0;
        for (int m = 0; m < N_MON; m++)
            if (grant_idx == 4'(m)) grant_time = tstamp[m];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts       <= '0;
            tstamp   <= '0;
            rpt_time <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            for (int m = 0; m < N_MON; m++)
                if (conf[m] && !clear) tstamp[m] <= ts;
            if (load) rpt_time <= grant_time;
        end
    end
`else
    assign rpt_time = '0;
`endif

endmodule

// File: tb/tb_phase_capture_deadlock_scheduler.sv
module tb_phase_capture_deadlock_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = 32;

    logic            clock = 1'b0;
    logic            reset, enable, clear, rpt_ready;
    logic [15:0]     persist_thresh;
    logic [N-1:0]    mon_block;
    logic [N*IW-1:0] mon_info;
    logic            rpt_valid, any_deadlock;
    logic [3:0]      rpt_idx;
    logic [IW-1:0]   rpt_info;
    logic [TW-1:0]   rpt_time;
    logic [N-1:0]    sticky;

    typedef struct {
        logic [3:0]    idx;
        logic [IW-1:0] info;
        logic [TW-1:0] t;
    } rpt_t;

    rpt_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [TW-1:0] tb_ts = '0;

    phase_capture_deadlock_scheduler #(.N_MON(N), .INFO_W(IW), .TS_W(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .clear          (clear),
        .persist_thresh (persist_thresh),
        .mon_block      (mon_block),
        .mon_info       (mon_info),
        .rpt_valid      (rpt_valid),
        .rpt_ready      (rpt_ready),
        .rpt_idx        (rpt_idx),
        .rpt_info       (rpt_info),
        .rpt_time       (rpt_time),
        .sticky         (sticky),
        .any_deadlock   (any_deadlock)
    );

    always #5 clock = ~clock;

    // Reference timestamp: equals the design's ts during the current cycle.
    always @(posedge clock) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int idx, input logic [IW-1:0] info, input logic [TW-1:0] t);
        rpt_t e;
        e.idx  = 4'(idx);
        e.info = info;
`ifdef PHASE_CAPTURE_DLSCHED_TIMESTAMP_EN
        e.t    = t;
`else
        e.t    = '0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted report is matched against the queue head.
    always @(negedge clock) begin
        if (!reset && rpt_valid && rpt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rpt", {rpt_valid & rpt_ready}, 0);
            end else begin
                rpt_t e;
                e = exp_q.pop_front();
                chk("rpt_idx", rpt_idx, e.idx);
                chk("rpt_info", rpt_info, e.info);
                chk("rpt_time", rpt_time, e.t);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; rpt_ready = 1'b1;
        persist_thresh = 16'd3; mon_block = '0; mon_info = '0;
        tick(2);
        chk("rst_valid", rpt_valid, 0);
        chk("rst_idx", rpt_idx, 0);
        chk("rst_info", rpt_info, 0);
        chk("rst_time", rpt_time, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_any", any_deadlock, 0);
        reset = 1'b0;
        tick();

        // Persistence threshold 3: a 2-cycle burst must not confirm.
        mon_info  = 8'b00_10_00_00;
        mon_block = 4'b0100;
        tick(2);
        mon_block = 4'b0000;
        tick();
        chk("t1_short_burst", sticky, 4'b0000);
        mon_block = 4'b0100;
        push(2, 2'b10, tb_ts + 2);
        tick();
        chk("t1_c1_sticky", sticky, 4'b0000);
        tick();
        chk("t1_c2_sticky", sticky, 4'b0000);
        tick();
        chk("t1_c3_sticky", sticky, 4'b0100);
        chk("t1_c3_any", any_deadlock, 1);
        chk("t1_c3_valid", rpt_valid, 0);
        mon_block = 4'b0000;
        tick();
        chk("t1_c4_valid", rpt_valid, 1);
        tick();
        chk("t1_c5_valid", rpt_valid, 0);
        drain("t1_drain");

        // Round-robin with backpressure, payload captured at confirmation.
        do_reset();
        persist_thresh = 16'd1;
        rpt_ready = 1'b0;
        mon_info  = 8'b11_00_10_01;
        mon_block = 4'b1011;
        push(0, 2'b01, tb_ts);
        push(1, 2'b10, tb_ts);
        push(3, 2'b11, tb_ts);
        tick();
        chk("t2_sticky", sticky, 4'b1011);
        mon_block = 4'b0000;
        mon_info  = ~mon_info;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", rpt_valid, 1);
            chk("t2_stall_idx", rpt_idx, 0);
            chk("t2_stall_info", rpt_info, 2'b01);
            tick();
        end
        rpt_ready = 1'b1;
        tick();
        chk("t2_gap_valid", rpt_valid, 0);
        tick();
        chk("t2_second_valid", rpt_valid, 1);
        chk("t2_second_idx", rpt_idx, 1);
        tick();
        chk("t2_gap2_valid", rpt_valid, 0);
        drain("t2_drain");

        // Clear during the idx 1 report while idx 3 is pending.
        do_reset();
        persist_thresh = 16'd2;
        rpt_ready = 1'b0;
        mon_info  = 8'b11_00_10_00;
        mon_block = 4'b1010;
        push(1, 2'b10, tb_ts + 1);
        tick(3);
        chk("t4_valid", rpt_valid, 1);
        chk("t4_idx", rpt_idx, 1);
        clear = 1'b1;
        mon_block = 4'b1000;
        tick();
        clear = 1'b0;
        mon_info = 8'b01_00_00_00;
        chk("t4_sticky_clr", sticky, 4'b0000);
        chk("t4_valid_held", rpt_valid, 1);
        chk("t4_idx_held", rpt_idx, 1);
        push(3, 2'b01, tb_ts + 1);
        rpt_ready = 1'b1;
        tick();
        chk("t4_pre_reconf", sticky, 4'b0000);
        tick();
        chk("t4_reconf", sticky, 4'b1000);
        mon_block = 4'b0000;
        drain("t4_drain");

        // Reset drops an in-flight report.
        do_reset();
        persist_thresh = 16'd1;
        rpt_ready = 1'b0;
        mon_block = 4'b0001;
        tick(2);
        chk("t5_valid", rpt_valid, 1);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid", rpt_valid, 0);
        chk("t5_rst_sticky", sticky, 0);
        chk("t5_rst_idx", rpt_idx, 0);
        reset = 1'b0;
        // Held block with no clear: exactly one report.
        mon_info  = 8'b00_00_00_11;
        rpt_ready = 1'b1;
        push(0, 2'b11, tb_ts);
        tick(30);
        chk("t5_one_report", exp_q.size(), 0);
        chk("t5_sticky", sticky, 4'b0001);
        mon_block = 4'b0000;

        // Threshold 0 behaves as 1.
        do_reset();
        persist_thresh = 16'd0;
        mon_info  = 8'b00_01_00_00;
        mon_block = 4'b0100;
        push(2, 2'b01, tb_ts);
        tick();
        chk("t6_thr0_sticky", sticky, 4'b0100);
        mon_block = 4'b0000;
        drain("t6_drain");

        // Enable low: nothing confirms.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b0;
        mon_block = 4'b1111;
        tick(100);
        chk("t6_dis_sticky", sticky, 0);
        chk("t6_dis_any", any_deadlock, 0);
        chk("t6_dis_valid", rpt_valid, 0);
        mon_block = 4'b0000;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1);
    end
endmodule

// File: doc/phase_capture_deadlock_scheduler.md
# phase_capture_deadlock_scheduler

Collects the `block` / `axis_block_info` outputs of up to N per-instance deadlock monitors in the phase-capture dataflow. It debounces each one with a programmable persistence threshold and latches confirmed deadlocks into sticky status. Confirmed events are serialized through a round-robin arbiter onto a single valid/ready report channel read by the control-plane logger. It sits between the HLS deadlock monitors and the AXI-Lite status/interrupt block.

## Interface
- `N_MON`, 4: number of monitored instances (1..16).
- `INFO_W`, 1: width of each monitor's `axis_block_info`.
- `TS_W`, 32: timestamp width.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 1 = detection active; 0 = persistence counters held at 0 and no new confirmations.
- `clear` in 1: single-cycle pulse; clears sticky status, pending flags and counters.
- `persist_thresh` in 16: number of consecutive `block` cycles required to confirm; 0 is treated as 1.
- `mon_block` in N_MON: `block` output of each monitor.
- `mon_info` in N_MON*INFO_W: `axis_block_info` of each monitor; monitor i occupies bits [i*INFO_W +: INFO_W].
- `rpt_valid` out 1: report available.
- `rpt_ready` in 1: consumer accepts the report.
- `rpt_idx` out 4: index of the reported monitor.
- `rpt_info` out INFO_W: info captured at confirmation.
- `rpt_time` out TS_W: timestamp captured at confirmation.
- `sticky` out N_MON: bit i = monitor i confirmed since the last clear/reset.
- `any_deadlock` out 1: OR of `sticky`.

## Operation
- **Free-running counter `ts`:**
  - TS_W bits; increments every cycle; wraps 2^TS_W−1 → 0.
  - Reset to 0; `clear` does not affect it.
- **Per-monitor persistence counter `cnt[i]`:**
  - 16-bit.
  - If `enable` && `mon_block[i]`: `cnt[i]` ← min(`cnt[i]`+1, thr), where thr = max(`persist_thresh`, 1).
  - Otherwise `cnt[i]` ← 0.
- **Confirm event `conf[i]`:** fires when `enable`, `mon_block[i]`, `cnt[i]` == thr−1, and `sticky[i]` == 0.
  - On that edge, set `sticky[i]` and `pending[i]`.
  - Capture `info[i]` ← `mon_info` slice and `tstamp[i]` ← `ts`.
  - While `sticky[i]` is set, monitor i is never confirmed again until clear/reset.
- **FSM states:** IDLE, REPORT.
  - **IDLE:** if any `pending` bit is set, the round-robin grant picks the first set bit searching upward from `last`+1 (mod N_MON).
    - Load `rpt_idx`, `rpt_info` and `rpt_time` from that slot; set `last` ← grant.
    - Go to REPORT; `rpt_valid` = 1 from the next cycle.
  - **REPORT:** hold `rpt_valid` and the payload stable.
    - On `rpt_valid` && `rpt_ready`: clear `pending[rpt_idx]` and go to IDLE.
- **Clear:**
  - On the `clear` edge, `sticky`, `pending` and `cnt` are cleared.
  - A `conf` in the same cycle loses: clear wins.
  - A report already in REPORT is not retracted; it completes normally. Its `pending` bit is already 0, so nothing is re-reported.
- **`enable` low:** counters are zeroed and no confirmations occur. Reports already pending continue to drain.
- **Bounds:** `rpt_idx` is zero-extended to 4 bits; unused `sticky` bits do not exist.

## Timing
- **Reset values:** `rpt_valid` = 0, `rpt_idx` = 0, `rpt_info` = 0, `rpt_time` = 0, `sticky` = 0, `any_deadlock` = 0. Internally `last` = N_MON−1, so the first grant goes to index 0.
- **Latency:**
  - `mon_block[i]` rising in cycle 0 (held high) → `sticky[i]` visible in cycle thr.
  - `any_deadlock` is visible in the same cycle as `sticky[i]` (registered OR, or combinational from `sticky`; implementer's choice, but it must match this latency).
  - `rpt_valid` rises in cycle thr+1 if the FSM is idle.
- **Throughput:** a minimum of one IDLE cycle between consecutive reports. Back-to-back acceptance therefore yields one report per 2 cycles.
- **Handshake:** AXI-Stream style.
  - The payload must not change while `rpt_valid` && !`rpt_ready`.
  - `rpt_valid` never drops without acceptance, except on `reset`.
- **Reset mid-operation:** everything returns to reset values on the next edge, including an in-flight report, which is dropped.

## Configuration
- **`PHASE_CAPTURE_DLSCHED_TIMESTAMP_EN`:**
  - **Defined:** the `ts` counter and the per-slot `tstamp` registers are built, and `rpt_time` carries the captured value.
  - **Undefined:** no counter or timestamp storage is built, and `rpt_time` is tied to 0. All other behaviour is identical.

## Test plan
- **Persistence threshold:** `persist_thresh` = 3; `mon_block[2]` high for 2 cycles, low, then high for 3 cycles → `sticky` = 4'b0100 only after the second burst; one report with `rpt_idx` = 2.
- **Round-robin with backpressure:** `persist_thresh` = 1; `mon_block` = 4'b1011 simultaneously; `rpt_ready` held low for 5 cycles, then high → reports in order idx 0, 1, 3; payload stable throughout the stall; 2 cycles per report once ready.
- **Captured payload:** `mon_info[1]` = 0 at the confirm edge, toggled afterward → `rpt_info` = 0. With the macro defined, `rpt_time` equals the `ts` value sampled at the confirm edge.
- **Clear during report:** `clear` pulsed during REPORT for idx 1 while idx 3 is pending → idx 1 report completes; idx 3 is never reported; `sticky` = 0; with `mon_block[3]` still high, idx 3 re-confirms after thr cycles.
- **Reset and sticky suppression:** `reset` asserted with `rpt_valid` = 1 → next cycle `rpt_valid` = 0 and `sticky` = 0. Separately, with `mon_block[0]` held high and no clear → exactly one report ever.
- **Threshold 0 and `enable`:** `persist_thresh` = 0 behaves as 1. `enable` = 0 with `mon_block` = all ones for 100 cycles → no `sticky` bits set and no reports.
